// File: rtl/cache_controller_pkg.sv
// Shared types and constants for the direct-mapped read cache.
// The CPU word address is split into tag, line index and word offset.
package cache_controller_pkg;

  localparam int WORD_LENGTH  = 32;
  localparam int TAG_WIDTH    = 3;
  localparam int INDEX_WIDTH  = 10;
  localparam int OFFSET_WIDTH = 2;
  localparam int BLOCK_WORDS  = 4;
  localparam int SETS         = 1 << INDEX_WIDTH;
  localparam int ADDR_WIDTH   = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;

  typedef enum logic [2:0] {
    CC_IDLE,
    CC_LOOKUP,
    CC_MISS,
    CC_FILL,
    CC_RESPOND
  } cc_state_e;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]    tag;
    logic [INDEX_WIDTH-1:0]  index;
    logic [OFFSET_WIDTH-1:0] offset;
  } cpu_addr_t;

  // Word 0 of a block sits in the least significant slice.
  typedef logic [BLOCK_WORDS-1:0][WORD_LENGTH-1:0] block_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU request/response and main_memory read signals of the cache.
// slave is the cache controller's view; master is the CPU + memory side.
interface cache_controller_if;
  import cache_controller_pkg::*;

  logic                   cpu_req;
  logic [ADDR_WIDTH-1:0]  cpu_address;
  logic                   cpu_ready;
  logic                   cpu_data_valid;
  logic [WORD_LENGTH-1:0] cpu_data;
  logic                   cpu_hit;

  logic [ADDR_WIDTH-1:0]  mem_address;
  logic                   mem_hit;
  logic [WORD_LENGTH-1:0] mem_data1;
  logic [WORD_LENGTH-1:0] mem_data2;
  logic [WORD_LENGTH-1:0] mem_data3;
  logic [WORD_LENGTH-1:0] mem_data4;

  modport slave (
    input  cpu_req, cpu_address, mem_data1, mem_data2, mem_data3, mem_data4,
    output cpu_ready, cpu_data_valid, cpu_data, cpu_hit, mem_address, mem_hit
  );

  modport master (
    output cpu_req, cpu_address, mem_data1, mem_data2, mem_data3, mem_data4,
    input  cpu_ready, cpu_data_valid, cpu_data, cpu_hit, mem_address, mem_hit
  );

endinterface

// File: rtl/cache_controller_line_store.sv
// Valid/tag/data storage for every cache line, with combinational read.
// Only the valid bits are reset; stale tags and data are masked by valid.
module cache_line_store
  import cache_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic                   we,
  input  logic [TAG_WIDTH-1:0]   tag_in,
  input  block_t                 data_in,
  output logic                   valid,
  output logic [TAG_WIDTH-1:0]   tag,
  output block_t                 data
);

  logic [SETS-1:0]      valid_q;
  logic [TAG_WIDTH-1:0] tag_mem  [SETS];
  block_t               data_mem [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[index] <= 1'b1;
    end
  end

  // NOTE: storage arrays carry no reset so they map onto plain RAM; valid alone decides a hit.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[index]  <= tag_in;
      data_mem[index] <= data_in;
    end
  end

  assign valid = valid_q[index];
  assign tag   = tag_mem[index];
  assign data  = data_mem[index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped 4-word-block read cache: lookup, miss wait, block fill and
// response sequencing, plus saturating access/hit statistics.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  cache_controller_if.slave bus,
  output logic [31:0]       access_count,
  output logic [31:0]       hit_count
);

  localparam int CTR_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  cc_state_e              state;
  cpu_addr_t              req;
  logic [CTR_W-1:0]       ctr;
  logic                   cpu_ready_q;
  logic                   cpu_data_valid_q;
  logic [WORD_LENGTH-1:0] cpu_data_q;
  logic                   cpu_hit_q;
  logic [ADDR_WIDTH-1:0]  mem_address_q;
  logic                   mem_hit_q;

  logic                   line_valid;
  logic [TAG_WIDTH-1:0]   line_tag;
  block_t                 line_data;
  block_t                 fill_block;
  logic                   lookup_hit;

  assign fill_block = {bus.mem_data4, bus.mem_data3, bus.mem_data2, bus.mem_data1};
  assign lookup_hit = line_valid && (line_tag == req.tag);

  cache_line_store u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .index   (req.index),
    .we      (state == CC_FILL),
    .tag_in  (req.tag),
    .data_in (fill_block),
    .valid   (line_valid),
    .tag     (line_tag),
    .data    (line_data)
  );

  // NOTE: every register below uses non-blocking assignment so all state updates on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= CC_IDLE;
      req              <= '0;
      ctr              <= '0;
      cpu_ready_q      <= 1'b1;
      cpu_data_valid_q <= 1'b0;
      cpu_data_q       <= '0;
      cpu_hit_q        <= 1'b0;
      mem_address_q    <= '0;
      mem_hit_q        <= 1'b1;
      access_count     <= '0;
      hit_count        <= '0;
    end else begin
      cpu_data_valid_q <= 1'b0;
      case (state)
        CC_IDLE: begin
          if (bus.cpu_req) begin
            req          <= cpu_addr_t'(bus.cpu_address);
            access_count <= sat_inc(access_count);
            cpu_ready_q  <= 1'b0;
            state        <= CC_LOOKUP;
          end
        end
        CC_LOOKUP: begin
          if (lookup_hit) begin
            hit_count  <= sat_inc(hit_count);
            cpu_data_q <= line_data[req.offset];
            cpu_hit_q  <= 1'b1;
            state      <= CC_RESPOND;
          end else begin
            mem_address_q <= {req.tag, req.index, {OFFSET_WIDTH{1'b0}}};
            mem_hit_q     <= 1'b0;
            ctr           <= CTR_W'(MEM_LATENCY - 1);
            state         <= CC_MISS;
          end
        end
        CC_MISS: begin
          // Releasing mem_hit on the way into FILL keeps the request low exactly MEM_LATENCY cycles.
          if (ctr == '0) begin
            mem_hit_q <= 1'b1;
            state     <= CC_FILL;
          end else begin
            ctr <= ctr - 1'b1;
          end
        end
        CC_FILL: begin
          cpu_data_q <= fill_block[req.offset];
          cpu_hit_q  <= 1'b0;
          state      <= CC_RESPOND;
        end
        CC_RESPOND: begin
          cpu_data_valid_q <= 1'b1;
          cpu_ready_q      <= 1'b1;
          state            <= CC_IDLE;
        end
        default: state <= CC_IDLE;
      endcase
    end
  end

  assign bus.cpu_ready      = cpu_ready_q;
  assign bus.cpu_data_valid = cpu_data_valid_q;
  assign bus.cpu_data       = cpu_data_q;
  assign bus.cpu_hit        = cpu_hit_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_hit        = mem_hit_q;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural main_memory
// (RAM[i]=i, RAM[4101]=32'h0000_A5A5).
module tb_cache_controller;
  import cache_controller_pkg::*;

  localparam int MEM_LATENCY = 4;
  localparam int MISS_LAT    = MEM_LATENCY + 3;
  localparam int HIT_LAT     = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] access_count;
  logic [31:0] hit_count;
  int          n_checks;
  int          n_errors;

  cache_controller_if bus ();

  cache_controller #(.MEM_LATENCY(MEM_LATENCY)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .access_count (access_count),
    .hit_count    (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [ADDR_WIDTH-1:0] a);
    return (a == 15'd4101) ? 32'h0000_A5A5 : {17'd0, a};
  endfunction

  always_comb begin
    bus.mem_data1 = ram_word(bus.mem_address);
    bus.mem_data2 = ram_word(bus.mem_address + 15'd1);
    bus.mem_data3 = ram_word(bus.mem_address + 15'd2);
    bus.mem_data4 = ram_word(bus.mem_address + 15'd3);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for cpu_data_valid; returns cycles since the accept edge (0 on timeout).
  task automatic wait_valid(input int start, output int lat, output int low_cycles,
                            output bit addr_bad, input logic [ADDR_WIDTH-1:0] exp_maddr);
    lat        = 0;
    low_cycles = 0;
    addr_bad   = 1'b0;
    for (int i = start; i <= 40; i++) begin
      tick();
      if (!bus.mem_hit) begin
        low_cycles++;
        if (bus.mem_address !== exp_maddr) addr_bad = 1'b1;
      end
      if (bus.cpu_data_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_access(input string tag, input logic [ADDR_WIDTH-1:0] addr,
                            input logic [31:0] exp_data, input bit exp_hit,
                            input logic [ADDR_WIDTH-1:0] exp_maddr);
    int lat;
    int low_cycles;
    bit addr_bad;
    check({tag, "_ready"}, 32'(bus.cpu_ready), 32'd1);
    bus.cpu_address = addr;
    bus.cpu_req     = 1'b1;
    tick();
    bus.cpu_req = 1'b0;
    wait_valid(1, lat, low_cycles, addr_bad, exp_maddr);
    check({tag, "_latency"}, 32'(lat), exp_hit ? 32'(HIT_LAT) : 32'(MISS_LAT));
    check({tag, "_mem_low"}, 32'(low_cycles), exp_hit ? 32'd0 : 32'(MEM_LATENCY));
    check({tag, "_mem_addr_bad"}, 32'(addr_bad), 32'd0);
    check({tag, "_data"}, bus.cpu_data, exp_data);
    check({tag, "_hit"}, 32'(bus.cpu_hit), 32'(exp_hit));
    check({tag, "_mem_addr"}, 32'(bus.mem_address), 32'(exp_maddr));
    tick();
    check({tag, "_valid_pulse"}, 32'(bus.cpu_data_valid), 32'd0);
    check({tag, "_data_hold"}, bus.cpu_data, exp_data);
  endtask

  initial begin
    int lat;
    int low_cycles;
    bit addr_bad;
    n_checks        = 0;
    n_errors        = 0;
    bus.cpu_req     = 1'b0;
    bus.cpu_address = '0;
    rst_n           = 1'b0;

    // 1. reset
    repeat (3) tick();
    check("rst_ready", 32'(bus.cpu_ready), 32'd1);
    check("rst_mem_hit", 32'(bus.mem_hit), 32'd1);
    check("rst_valid", 32'(bus.cpu_data_valid), 32'd0);
    check("rst_access", access_count, 32'd0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_mem_addr", 32'(bus.mem_address), 32'd0);
    rst_n = 1'b1;
    tick();

    // 2. cold miss
    run_access("cold5", 15'd5, 32'd5, 1'b0, 15'd4);
    check("cold5_access", access_count, 32'd1);
    check("cold5_hits", hit_count, 32'd0);

    // 3. same-block hit
    run_access("hit6", 15'd6, 32'd6, 1'b1, 15'd4);
    check("hit6_access", access_count, 32'd2);
    check("hit6_hits", hit_count, 32'd1);

    // 4. conflict eviction
    run_access("conf4101", 15'd4101, 32'h0000_A5A5, 1'b0, 15'd4100);
    run_access("evict5", 15'd5, 32'd5, 1'b0, 15'd4);
    check("evict_access", access_count, 32'd4);
    check("evict_hits", hit_count, 32'd1);

    // 5. request while busy is ignored
    bus.cpu_address = 15'd13;
    bus.cpu_req     = 1'b1;
    tick();
    bus.cpu_req = 1'b0;
    tick();
    check("busy_ready", 32'(bus.cpu_ready), 32'd0);
    bus.cpu_address = 15'd9;
    bus.cpu_req     = 1'b1;
    tick();
    bus.cpu_req = 1'b0;
    check("busy_access", access_count, 32'd5);
    check("busy_mem_addr", 32'(bus.mem_address), 32'd12);
    check("busy_mem_hit", 32'(bus.mem_hit), 32'd0);
    wait_valid(3, lat, low_cycles, addr_bad, 15'd12);
    check("busy_latency", 32'(lat), 32'(MISS_LAT));
    check("busy_data", bus.cpu_data, 32'd13);
    check("busy_hit", 32'(bus.cpu_hit), 32'd0);
    check("busy_addr_bad", 32'(addr_bad), 32'd0);
    tick();
    check("busy_access_end", access_count, 32'd5);

    // 6. reset two cycles into MISS
    bus.cpu_address = 15'd4102;
    bus.cpu_req     = 1'b1;
    tick();
    bus.cpu_req = 1'b0;
    tick();
    tick();
    check("mid_mem_hit_before", 32'(bus.mem_hit), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_mem_hit", 32'(bus.mem_hit), 32'd1);
    check("mid_ready", 32'(bus.cpu_ready), 32'd1);
    check("mid_access", access_count, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_access("after6", 15'd6, 32'd6, 1'b0, 15'd4);
    check("after_access", access_count, 32'd1);
    check("after_hits", hit_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
